// File: rtl/norm_32.sv
// -----------------------------------------------------------------------------
// norm_32 -- iterative 32-bit normalizer
//
// Finds the left-shift amount that normalizes a 32-bit word. It returns the
// shifted word and the amount, either as a leading-zero count (arith=0) or as
// a redundant-sign-bit count (arith=1). One binary-search stage (16, 8, 4, 2,
// 1) is resolved per cycle, so every operation takes exactly 5 cycles from
// acceptance to result.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid_i   operand present
//   in_ready_o   block can accept an operand (IDLE only)
//   a_i          operand
//   arith_i      0: count leading zeros, 1: count redundant sign bits
//   out_valid_o  result present (DONE only)
//   out_ready_i  consumer takes the result
//   q_o          normalized word (a_i << cnt_o, zero-filled)
//   cnt_o        shift amount, 0..32
//   z_o          operand was zero
// -----------------------------------------------------------------------------
module norm_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] a_i,
    input  logic        arith_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] q_o,
    output logic [5:0]  cnt_o,
    output logic        z_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S16  = 3'd1,
        S8   = 3'd2,
        S4   = 3'd3,
        S2   = 3'd4,
        S1   = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        z_q, z_d;

    // In sign mode, "top n+1 bits all equal" is the same as "top n bits of
    // x XOR (x<<1) are all zero", so both modes share one zero test.
    logic [31:0] probe;
    assign probe = mode_q ? (x_q ^ {x_q[30:0], 1'b0}) : x_q;

    // Per-stage candidates: index 0 is the 16-bit stage, index 4 the 1-bit one.
    logic [4:0]  stage_hit;
    logic [31:0] stage_x   [5];
    logic [5:0]  stage_amt [5];

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int N = 16 >> gi;
            assign stage_hit[gi] = ~|probe[31:32-N];
            assign stage_x[gi]   = x_q << N;
            assign stage_amt[gi] = 6'(N);
        end
    endgenerate

    logic [2:0] sel;
    logic       active;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        z_d     = z_q;
        sel     = 3'd0;
        active  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    x_d     = a_i;
                    cnt_d   = 6'd0;
                    mode_d  = arith_i;
                    z_d     = (a_i == 32'd0);
                    state_d = S16;
                end
            end
            S16: begin sel = 3'd0; active = 1'b1; state_d = S8;   end
            S8:  begin sel = 3'd1; active = 1'b1; state_d = S4;   end
            S4:  begin sel = 3'd2; active = 1'b1; state_d = S2;   end
            S2:  begin sel = 3'd3; active = 1'b1; state_d = S1;   end
            S1:  begin sel = 3'd4; active = 1'b1; state_d = DONE; end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (active && stage_hit[sel]) begin
            x_d   = stage_x[sel];
            cnt_d = cnt_q + stage_amt[sel];
        end

        // The greedy stage sum saturates at 31; a zero operand in
        // leading-zero mode really needs 32.
        if (state_q == S1 && !mode_q && z_q) begin
            cnt_d = 6'd32;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= 32'd0;
            cnt_q   <= 6'd0;
            mode_q  <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign q_o         = x_q;
    assign cnt_o       = cnt_q;
    assign z_o         = z_q;

endmodule

// File: tb/tb_norm_32.sv
// -----------------------------------------------------------------------------
// tb_norm_32 -- self-checking bench for norm_32
//
// Directed vectors with hand-computed results, backpressure, mid-operation
// reset, and a randomized run against a reference count model.
// -----------------------------------------------------------------------------
module tb_norm_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] a_i;
    logic        arith_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] q_o;
    logic [5:0]  cnt_o;
    logic        z_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    norm_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .arith_i     (arith_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .q_o         (q_o),
        .cnt_o       (cnt_o),
        .z_o         (z_o)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: leading zeros (0..32) or redundant sign bits (0..31).
    function automatic logic [5:0] ref_cnt(input logic [31:0] a, input logic ar);
        logic [5:0] n;
        logic       run;
        n   = 6'd0;
        run = 1'b1;
        if (!ar) begin
            for (int i = 31; i >= 0; i--) begin
                if (run && !a[i]) n++;
                else run = 1'b0;
            end
        end else begin
            for (int i = 30; i >= 0; i--) begin
                if (run && (a[i] == a[31])) n++;
                else run = 1'b0;
            end
        end
        return n;
    endfunction

    // One complete transaction: accept, check latency, stall, check result,
    // hand off and check return to IDLE.
    task automatic run_op(input logic [31:0] a, input logic ar, input int stall,
                          input logic [31:0] eq, input logic [5:0] ec, input logic ez);
        int n;
        @(negedge clk);
        in_valid_i = 1'b1;
        a_i        = a;
        arith_i    = ar;
        n = 0;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("accept_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        a_i        = $urandom;
        arith_i    = 1'($urandom);
        n = 0;
        while (!out_valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value("latency", 32'(n), 32'd5);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        check_value("out_valid", 32'(out_valid_o), 32'd1);
        check_value("q", q_o, eq);
        check_value("cnt", 32'(cnt_o), 32'(ec));
        check_value("z", 32'(z_o), 32'(ez));
        $display("op a=0x%08h arith=%0d stall=%0d q=0x%08h cnt=%0d z=%0d", a, ar, stall, q_o, cnt_o, z_o);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        check_value("handoff_valid", 32'(out_valid_o), 32'd0);
        check_value("handoff_ready", 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rar;
        logic [5:0]  rc;

        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        a_i         = 32'd0;
        arith_i     = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_in_ready", 32'(in_ready_o), 32'd1);
        check_value("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_value("rst_q", q_o, 32'd0);
        check_value("rst_cnt", 32'(cnt_o), 32'd0);
        check_value("rst_z", 32'(z_o), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        run_op(32'h0000_0001, 1'b0, 0, 32'h8000_0000, 6'd31, 1'b0);
        run_op(32'h0000_0000, 1'b0, 1, 32'h0000_0000, 6'd32, 1'b1);
        run_op(32'h0000_0000, 1'b1, 0, 32'h0000_0000, 6'd31, 1'b1);
        run_op(32'hFFFF_FFF0, 1'b1, 2, 32'h8000_0000, 6'd27, 1'b0);
        run_op(32'h0001_2345, 1'b1, 0, 32'h48D1_4000, 6'd14, 1'b0);
        run_op(32'h8000_0000, 1'b1, 0, 32'h8000_0000, 6'd0,  1'b0);
        run_op(32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 6'd31, 1'b0);
        run_op(32'h8000_0000, 1'b0, 0, 32'h8000_0000, 6'd0,  1'b0);

        // Backpressure: 0x100 -> clz 23; a competing operand 0x3 must wait.
        @(negedge clk);
        in_valid_i = 1'b1;
        a_i        = 32'h0000_0100;
        arith_i    = 1'b0;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("bp_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid_i = (i != 1);
            a_i        = 32'h0000_0003;
            arith_i    = 1'b0;
            @(posedge clk);
            #1;
            check_value("bp_hold_valid", 32'(out_valid_o), 32'd1);
            check_value("bp_hold_ready", 32'(in_ready_o), 32'd0);
            check_value("bp_hold_q", q_o, 32'h8000_0000);
            check_value("bp_hold_cnt", 32'(cnt_o), 32'd23);
        end
        $display("op a=0x00000100 arith=0 backpressure q=0x%08h cnt=%0d", q_o, cnt_o);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        check_value("bp_release_valid", 32'(out_valid_o), 32'd0);
        check_value("bp_release_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        check_value("bp_accept_ready", 32'(in_ready_o), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_value("bp_early_valid", 32'(out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        check_value("bp_next_valid", 32'(out_valid_o), 32'd1);
        check_value("bp_next_q", q_o, 32'hC000_0000);
        check_value("bp_next_cnt", 32'(cnt_o), 32'd30);
        $display("op a=0x00000003 arith=0 after backpressure q=0x%08h cnt=%0d", q_o, cnt_o);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;

        // Reset during S4
        @(negedge clk);
        in_valid_i = 1'b1;
        a_i        = 32'h1234_5678;
        arith_i    = 1'b0;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_value("midrst_valid", 32'(out_valid_o), 32'd0);
        check_value("midrst_q", q_o, 32'd0);
        check_value("midrst_cnt", 32'(cnt_o), 32'd0);
        check_value("midrst_z", 32'(z_o), 32'd0);
        check_value("midrst_ready", 32'(in_ready_o), 32'd1);
        $display("reset during S4 applied");
        run_op(32'h0000_FFFF, 1'b0, 0, 32'hFFFF_0000, 6'd16, 1'b0);

        // Random operands against the reference count
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom >> $urandom_range(0, 32);
            rar = 1'($urandom);
            if ($urandom_range(0, 1) == 1) ra = ~ra;
            if ($urandom_range(0, 15) == 0) ra = 32'd0;
            rc = ref_cnt(ra, rar);
            run_op(ra, rar, int'($urandom_range(0, 3)), ra << rc, rc, (ra == 32'd0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
